// File: rtl/ipv4_tx_arb_pkg.sv
// ipv4_tx_arb_pkg: shared IPv4 TX constants, arbiter FSM states and index helper
package ipv4_tx_arb_pkg;
    localparam int IPV4_HEAD_LEN = 20;
    localparam logic [7:0] PROT_UDP = 8'd17;
    localparam logic [7:0] PROT_ICMP = 8'd1;
    localparam int TOT_LEN_W = 16;
    localparam int MAX_PAYLOAD = 65515;
    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_DATA} state_t;
    function automatic int wrap(int a, int b, int n);
        return (a + b) % n;
    endfunction
endpackage

// File: rtl/ipv4_tx_arb_if.sv
// ipv4_tx_arb_if: requester bundle and IPv4 TX side signals of the transmit arbiter
interface ipv4_tx_arb_if #(
    parameter int N_REQ = 2,
    parameter int DATA_W = 16,
    parameter int LEN_W = $clog2(DATA_W / 8) + 1
);
    import ipv4_tx_arb_pkg::*;
    logic [N_REQ-1:0] req_i, valid_i, last_i, ready_o, gnt_o;
    logic [N_REQ*TOT_LEN_W-1:0] req_len_i;
    logic [N_REQ*DATA_W-1:0] data_i;
    logic [N_REQ*LEN_W-1:0] len_i;
    logic start_o, valid_o, last_o, ready_i, cancel_o, len_err_o;
    logic [7:0] prot_o;
    logic [TOT_LEN_W-1:0] tot_len_o;
    logic [DATA_W-1:0] data_o;
    logic [LEN_W-1:0] len_o;
    modport master (
        input req_i, req_len_i, valid_i, data_i, len_i, last_i, ready_i,
        output ready_o, gnt_o, start_o, prot_o, tot_len_o, valid_o, data_o, len_o, last_o, cancel_o, len_err_o
    );
    modport slave (
        output req_i, req_len_i, valid_i, data_i, len_i, last_i, ready_i,
        input ready_o, gnt_o, start_o, prot_o, tot_len_o, valid_o, data_o, len_o, last_o, cancel_o, len_err_o
    );
endinterface

// File: rtl/ipv4_tx_arb_rr_arbiter.sv
// rr_arbiter: picks the first pending requester at or after the round-robin pointer
module rr_arbiter
    import ipv4_tx_arb_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int PW = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [N_REQ-1:0] pick,
    output logic [PW-1:0]    idx,
    output logic             any
);
    // scan farthest to nearest so the requester closest to the pointer wins
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req[wrap(int'(ptr), k, N_REQ)]) begin
                idx = PW'(wrap(int'(ptr), k, N_REQ));
                any = 1'b1;
            end
        end
        pick = N_REQ'(any) << idx;
    end
endmodule

// File: rtl/ipv4_tx_arb.sv
// ipv4_tx_arb: round-robin packet sequencer sharing the IPv4 TX datapath between requesters
module ipv4_tx_arb
    import ipv4_tx_arb_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int DATA_W = 16,
    parameter int LEN_W = $clog2(DATA_W / 8) + 1,
    parameter logic [N_REQ*8-1:0] PROT = {PROT_ICMP, PROT_UDP},
    parameter int IDLE_MAX = 16
) (
    input logic clk,
    input logic reset,
    ipv4_tx_arb_if.master bus
);
    localparam int PW = $clog2(N_REQ);
    localparam int WD_W = $clog2(IDLE_MAX);
    state_t state;
    logic [PW-1:0] rr, own, pick_idx;
    logic [N_REQ-1:0] gnt, pick;
    logic any, start, oversize, vld, acc, lst, expire;
    logic [7:0] prot;
    logic [TOT_LEN_W-1:0] tot_len, req_len, cnt, rl, sum;
    logic [WD_W-1:0] wd;
    logic [LEN_W-1:0] ln;

    rr_arbiter #(.N_REQ(N_REQ), .PW(PW)) u_rr (
        .req(bus.req_i), .ptr(rr), .pick(pick), .idx(pick_idx), .any(any)
    );

    assign rl = bus.req_len_i[pick_idx*TOT_LEN_W +: TOT_LEN_W];
    assign ln = bus.len_i[own*LEN_W +: LEN_W];
    assign lst = bus.last_i[own];
    assign vld = (state == S_DATA) && bus.valid_i[own];
    assign acc = vld && bus.ready_i;
    assign sum = cnt + TOT_LEN_W'(ln);
    assign expire = (state == S_DATA) && !bus.valid_i[own] && (wd == WD_W'(IDLE_MAX - 1));

    assign bus.gnt_o = gnt;
    assign bus.start_o = start;
    assign bus.prot_o = prot;
    assign bus.tot_len_o = tot_len;
    assign bus.ready_o = gnt & {N_REQ{(state == S_DATA) && bus.ready_i}};
    assign bus.valid_o = vld;
    assign bus.data_o = bus.data_i[own*DATA_W +: DATA_W];
    assign bus.len_o = ln;
    assign bus.last_o = (state == S_DATA) && lst;
    assign bus.cancel_o = expire;
    assign bus.len_err_o = oversize || (acc && lst && (sum != req_len));

    // packet FSM: pick owner, announce header for one cycle, then track bytes and idle time
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            rr <= '0;
            own <= '0;
            gnt <= '0;
            start <= 1'b0;
            oversize <= 1'b0;
            prot <= '0;
            tot_len <= '0;
            req_len <= '0;
            cnt <= '0;
            wd <= '0;
        end else begin
            start <= 1'b0;
            oversize <= 1'b0;
            case (state)
                S_IDLE: if (any) begin
                    state <= S_GRANT;
                    own <= pick_idx;
                    gnt <= pick;
                    start <= 1'b1;
                    prot <= PROT[pick_idx*8 +: 8];
                    req_len <= rl;
                    oversize <= rl > TOT_LEN_W'(MAX_PAYLOAD);
                    tot_len <= (rl > TOT_LEN_W'(MAX_PAYLOAD)) ? '1 : rl + TOT_LEN_W'(IPV4_HEAD_LEN);
                    cnt <= '0;
                    wd <= '0;
                end
                S_GRANT: state <= S_DATA;
                S_DATA: begin
                    cnt <= acc ? sum : cnt;
                    wd <= vld ? '0 : wd + 1'b1;
                    if ((acc && lst) || expire) begin
                        state <= S_IDLE;
                        gnt <= '0;
                        rr <= PW'(wrap(int'(own), 1, N_REQ));
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ipv4_tx_arb.sv
// tb_ipv4_tx_arb: directed stimulus with a queue scoreboard checked by a negedge monitor
module tb_ipv4_tx_arb;
    localparam int K_START = 0;
    localparam int K_BEAT = 1;
    localparam int K_LERR = 2;
    localparam int K_CANCEL = 3;
    typedef struct {
        int kind;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic fire, bad;
    int n_chk = 0;
    int n_fail = 0;
    exp_t q[$];

    ipv4_tx_arb_if bus ();
    ipv4_tx_arb dut (.clk(clk), .reset(reset), .bus(bus.master));

    always #5 clk = ~clk;

    function automatic logic [31:0] bt(logic [1:0] g, logic [1:0] l, logic lst);
        return {27'd0, g, l, lst};
    endfunction

    function automatic logic [31:0] hdr(logic [7:0] p, logic [15:0] t);
        return {8'd0, p, t};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    task automatic push(int kind, logic [31:0] a, logic [31:0] b);
        exp_t e;
        e.kind = kind;
        e.a = a;
        e.b = b;
        q.push_back(e);
    endtask

    task automatic pop(string name, int kind, logic [31:0] a, logic [31:0] b);
        exp_t e;
        n_chk++;
        if (q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: unexpected event a=%h b=%h", name, a, b);
        end else begin
            e = q.pop_front();
            if (e.kind != kind || e.a !== a || e.b !== b) begin
                n_fail++;
                $display("FAIL %s: got kind %0d a=%h b=%h want kind %0d a=%h b=%h",
                         name, kind, a, b, e.kind, e.a, e.b);
            end
        end
    endtask

    task automatic beat(int r, logic [15:0] d, logic [1:0] l, logic lst);
        logic got;
        got = 1'b0;
        bus.valid_i[r] = 1'b1;
        bus.data_i[r*16 +: 16] = d;
        bus.len_i[r*2 +: 2] = l;
        bus.last_i[r] = lst;
        for (int k = 0; k < 64 && !got; k++) begin
            @(negedge clk);
            got = bus.ready_o[r];
        end
        chk("beat_accept", 32'(got), 32'd1);
        @(posedge clk);
        #1;
        bus.valid_i[r] = 1'b0;
        bus.last_i[r] = 1'b0;
    endtask

    task automatic rr_pkt(int r, logic [15:0] d);
        push(K_START, 32'(1 << r), hdr((r == 1) ? 8'd1 : 8'd17, 16'd22));
        push(K_BEAT, 32'(d), bt(2'(1 << r), 2'd2, 1'b1));
        beat(r, d, 2'd2, 1'b1);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.start_o) pop("start", K_START, 32'(bus.gnt_o), hdr(bus.prot_o, bus.tot_len_o));
            if (bus.valid_o && bus.ready_i) pop("beat", K_BEAT, 32'(bus.data_o), bt(bus.gnt_o, bus.len_o, bus.last_o));
            if (bus.len_err_o) pop("len_err", K_LERR, 32'(bus.gnt_o), 32'd0);
            if (bus.cancel_o) pop("cancel", K_CANCEL, 32'(bus.gnt_o), 32'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.req_i = '0;
        bus.req_len_i = '0;
        bus.valid_i = '0;
        bus.data_i = '0;
        bus.len_i = '0;
        bus.last_i = '0;
        bus.ready_i = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_gnt", 32'(bus.gnt_o), 32'd0);
        chk("rst_start", 32'(bus.start_o), 32'd0);
        chk("rst_valid", 32'(bus.valid_o), 32'd0);
        chk("rst_last", 32'(bus.last_o), 32'd0);
        chk("rst_cancel", 32'(bus.cancel_o), 32'd0);
        chk("rst_len_err", 32'(bus.len_err_o), 32'd0);
        chk("rst_prot", 32'(bus.prot_o), 32'd0);
        chk("rst_tot_len", 32'(bus.tot_len_o), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // single UDP packet, 4 bytes in two beats
        bus.req_len_i[15:0] = 16'd4;
        bus.req_i = 2'b01;
        push(K_START, 32'd1, hdr(8'd17, 16'd24));
        push(K_BEAT, 32'h1234, bt(2'b01, 2'd2, 1'b0));
        push(K_BEAT, 32'h5678, bt(2'b01, 2'd2, 1'b1));
        @(negedge clk);
        chk("t1_no_start_yet", 32'(bus.start_o), 32'd0);
        @(posedge clk);
        #1 bus.req_i = '0;
        @(negedge clk);
        chk("t1_start", 32'(bus.start_o), 32'd1);
        chk("t1_gnt", 32'(bus.gnt_o), 32'd1);
        chk("t1_no_ready_in_grant", 32'(bus.ready_o), 32'd0);
        beat(0, 16'h1234, 2'd2, 1'b0);
        beat(0, 16'h5678, 2'd2, 1'b1);
        @(negedge clk);
        chk("t1_idle", 32'(bus.gnt_o), 32'd0);

        // both requesters held: owners alternate starting from the advanced pointer
        bus.req_len_i = {16'd2, 16'd2};
        bus.req_i = 2'b11;
        for (int i = 0; i < 4; i++) begin
            rr_pkt(1 - (i % 2), 16'hA000 + 16'(i));
            if (i == 3) bus.req_i = '0;
            @(negedge clk);
            chk("t2_gap", 32'(bus.gnt_o), 32'd0);
            if (i < 3) begin
                @(negedge clk);
                chk("t2_restart", 32'(bus.start_o), 32'd1);
            end
        end

        // declared 6 bytes, only 4 delivered
        bus.req_len_i[15:0] = 16'd6;
        bus.req_i = 2'b01;
        push(K_START, 32'd1, hdr(8'd17, 16'd26));
        push(K_BEAT, 32'hAAAA, bt(2'b01, 2'd2, 1'b0));
        push(K_BEAT, 32'hBBBB, bt(2'b01, 2'd2, 1'b1));
        push(K_LERR, 32'd1, 32'd0);
        @(posedge clk);
        #1 bus.req_i = '0;
        beat(0, 16'hAAAA, 2'd2, 1'b0);
        beat(0, 16'hBBBB, 2'd2, 1'b1);
        @(negedge clk);
        chk("t3_idle", 32'(bus.gnt_o), 32'd0);

        // owner 1 never sends: watchdog cancels, owner 0 follows
        bus.req_len_i = {16'd2, 16'd2};
        bus.req_i = 2'b11;
        push(K_START, 32'd2, hdr(8'd1, 16'd22));
        push(K_CANCEL, 32'd2, 32'd0);
        push(K_START, 32'd1, hdr(8'd17, 16'd22));
        push(K_BEAT, 32'hC0DE, bt(2'b01, 2'd2, 1'b1));
        @(posedge clk);
        @(negedge clk);
        fire = 1'b0;
        repeat (15) begin
            @(negedge clk);
            fire = fire | bus.cancel_o;
        end
        chk("t4_no_early_cancel", 32'(fire), 32'd0);
        @(negedge clk);
        chk("t4_cancel", 32'(bus.cancel_o), 32'd1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 bus.req_i = '0;
        beat(0, 16'hC0DE, 2'd2, 1'b1);
        @(negedge clk);
        chk("t4_idle", 32'(bus.gnt_o), 32'd0);

        // TX back-pressure for 40 cycles: beat held, no watchdog
        bus.ready_i = 1'b0;
        bus.req_i = 2'b10;
        bus.valid_i[1] = 1'b1;
        bus.data_i[31:16] = 16'h5A5A;
        bus.len_i[3:2] = 2'd2;
        bus.last_i[1] = 1'b1;
        push(K_START, 32'd2, hdr(8'd1, 16'd22));
        push(K_BEAT, 32'h5A5A, bt(2'b10, 2'd2, 1'b1));
        @(posedge clk);
        #1 bus.req_i = '0;
        @(negedge clk);
        bad = 1'b0;
        repeat (40) begin
            @(negedge clk);
            bad = bad | bus.cancel_o | !bus.valid_o | (bus.data_o !== 16'h5A5A);
        end
        chk("t5_stall_hold", 32'(bad), 32'd0);
        @(posedge clk);
        #1 bus.ready_i = 1'b1;
        beat(1, 16'h5A5A, 2'd2, 1'b1);
        @(negedge clk);
        chk("t5_idle", 32'(bus.gnt_o), 32'd0);

        // oversize request: saturated total length, error in GRANT and at last beat
        bus.req_len_i[15:0] = 16'd65520;
        bus.req_i = 2'b01;
        push(K_START, 32'd1, hdr(8'd17, 16'hFFFF));
        push(K_LERR, 32'd1, 32'd0);
        push(K_BEAT, 32'h0F0F, bt(2'b01, 2'd2, 1'b1));
        push(K_LERR, 32'd1, 32'd0);
        @(posedge clk);
        #1 bus.req_i = '0;
        @(negedge clk);
        chk("t6_len_err_grant", 32'(bus.len_err_o), 32'd1);
        beat(0, 16'h0F0F, 2'd2, 1'b1);
        @(negedge clk);

        // reset in the middle of a packet
        bus.req_len_i[31:16] = 16'd4;
        bus.req_i = 2'b10;
        push(K_START, 32'd2, hdr(8'd1, 16'd24));
        @(posedge clk);
        #1;
        bus.req_i = '0;
        bus.ready_i = 1'b0;
        bus.valid_i[1] = 1'b1;
        bus.data_i[31:16] = 16'h7777;
        bus.last_i[1] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("t7_valid_before_rst", 32'(bus.valid_o), 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("t7_rst_gnt", 32'(bus.gnt_o), 32'd0);
        chk("t7_rst_valid", 32'(bus.valid_o), 32'd0);
        chk("t7_rst_cancel", 32'(bus.cancel_o), 32'd0);
        chk("t7_rst_start", 32'(bus.start_o), 32'd0);
        @(posedge clk);
        #1;
        bus.valid_i = '0;
        bus.ready_i = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        bus.req_len_i = {16'd2, 16'd2};
        bus.req_i = 2'b11;
        push(K_START, 32'd1, hdr(8'd17, 16'd22));
        push(K_BEAT, 32'h1111, bt(2'b01, 2'd2, 1'b1));
        push(K_START, 32'd2, hdr(8'd1, 16'd22));
        push(K_BEAT, 32'h2222, bt(2'b10, 2'd2, 1'b1));
        @(posedge clk);
        #1 bus.req_i = 2'b10;
        beat(0, 16'h1111, 2'd2, 1'b1);
        @(posedge clk);
        #1 bus.req_i = '0;
        beat(1, 16'h2222, 2'd2, 1'b1);
        @(negedge clk);
        chk("t7_idle", 32'(bus.gnt_o), 32'd0);

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ipv4_tx_arb.md
# ipv4_tx_arb

Round-robin arbiter and packet sequencer sharing the single IPv4 transmit datapath between N_REQ transport-layer requesters (UDP sockets, ICMP responder). Grants one requester per packet, presents its protocol and total length to the IPv4 header generator, then forwards payload beats until the last one. Enforces payload length consistency and a starvation watchdog. Sits between the transport layer and the IPv4 TX header inserter, mirroring the filtering done on the RX side.

## Interface
- N_REQ, 2: number of requesters (2..8)
- DATA_W, 16: payload beat width; only 16 supported
- LEN_W, $clog2(DATA_W/8)+1: byte-count width; len = valid bytes in beat, 1..DATA_W/8
- PROT, {8'd1, 8'd17}: N_REQ×8 vector, protocol per requester; requester i uses PROT[8i+:8]
- IDLE_MAX, 16: consecutive granted-but-not-valid cycles before abort

- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- req_i  in  N_REQ  requester i has a packet pending
- req_len_i  in  N_REQ×16  payload byte length per requester, sampled at grant
- valid_i  in  N_REQ  payload beat valid
- data_i  in  N_REQ×DATA_W  payload beats
- len_i  in  N_REQ×LEN_W  valid bytes per beat
- last_i  in  N_REQ  final payload beat
- ready_o  out  N_REQ  beat accepted from requester i
- gnt_o  out  N_REQ  one-hot, current packet owner
- start_o  out  1  one-cycle pulse, prot_o/tot_len_o valid
- prot_o  out  8  IPv4 protocol field
- tot_len_o  out  16  IPv4 total length = payload + 20
- valid_o, data_o, len_o, last_o  out  1/DATA_W/LEN_W/1  payload to IPv4 TX
- ready_i  in  1  IPv4 TX accepts beat
- cancel_o  out  1  one-cycle pulse, packet aborted
- len_err_o  out  1  one-cycle pulse, byte count mismatch or oversize

## Operation
- States: IDLE, GRANT, DATA.
- IDLE: if any req_i, pick first set requester starting at rr pointer, wrapping; register owner, prot, req_len+20 → GRANT. No req: stay.
- Oversize: req_len > 65515 at pick → still granted, len_err_o pulses in GRANT, tot_len_o saturates to 16'hFFFF.
- GRANT (1 cycle): start_o=1, gnt_o held; → DATA unconditionally. req_i drop after pick is ignored.
- DATA: ready_o[g] = ready_i; valid_o=valid_i[g]; data/len/last muxed from owner. Beat accepted when valid_o & ready_i; byte counter += len.
- Accepted last beat: if counter+len != latched req_len → len_err_o pulse same cycle; → IDLE; rr pointer = owner+1 mod N_REQ.
- Watchdog: counts DATA cycles with valid_i[g]=0; cleared on any valid. Reaching IDLE_MAX → cancel_o pulse, → IDLE, rr pointer advances. ready_i low with valid high does not count.
- Non-owners: ready_o=0, gnt_o bit 0, beats ignored.
- 16-bit counters wrap silently; mismatch detection covers the case.

## Timing
- Reset (async): state IDLE, rr pointer 0, gnt_o=0, start_o=0, valid_o=0, last_o=0, cancel_o=0, len_err_o=0, prot_o=0, tot_len_o=0.
- req_i at cycle t in IDLE → start_o and gnt_o at t+1; first beat forwardable at t+2.
- Datapath combinational owner→valid_o and ready_i→ready_o; zero latency.
- After last accepted at t, IDLE at t+1, next start_o at t+2 earliest.
- Last beat and watchdog expiry in same cycle: last wins, no cancel.
- prot_o/tot_len_o stable from GRANT until IDLE.
- Reset mid-packet: all outputs 0 immediately; no cancel_o pulse.

## Structure
- ipv4_pkg: IPV4_HEAD_LEN=20, PROT_UDP=8'd17, PROT_ICMP=8'd1, TOT_LEN_W=16, MAX_PAYLOAD=65515, state enum.
- Sub-module rr_arbiter: combinational N_REQ request vector + pointer → one-hot pick + valid.

## Test plan
- Single req0, req_len=4, two 2-byte beats, ready_i=1 → start_o cycle after req, prot_o=17, tot_len_o=24, last_o on beat 2, no errors.
- req0 and req1 held continuously → grants alternate 0,1,0,1, one IDLE cycle between packets.
- req_len=6, last after 4 bytes → len_err_o pulses with last beat, state IDLE.
- Owner valid low 16 cycles → cancel_o pulse at cycle 16, next grant goes to other requester.
- ready_i low 40 cycles, valid high → no cancel, beats held, data_o stable.
- Reset asserted mid-DATA → gnt_o, valid_o 0 same cycle; after release req1 granted first only if req0 low.
